se_fc_reduce: RTL and testbench
===============================

# se_fc_reduce

Serial fully-connected reduction stage of the SE layer. It accepts one pooled channel vector of IN_CH signed Q8.8 values, one value per cycle. It computes OUT_CH dot products against an on-chip weight memory, adds the matching bias from a bias memory, then rounds and saturates each result. The OUT_CH results stream out one per cycle with a valid pulse, directly into the serial ReLU stage, which has no backpressure.

## Interface
- DATA_WIDTH, 16, signed Q8.8 width of activations, weights and biases
- FRAC_BITS, 8, fractional bits
- IN_CH, 16, input vector length
- OUT_CH, 4, output neurons
- ACC_WIDTH, 40, signed accumulator width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_data  input  DATA_WIDTH  signed input element
- in_valid  input  1  in_data valid
- in_ready  output  1  stage accepts input this cycle
- w_we  input  1  weight write enable
- w_addr  input  $clog2(IN_CH*OUT_CH)  weight address, o*IN_CH+i
- w_data  input  DATA_WIDTH  signed weight
- b_we  input  1  bias write enable
- b_addr  input  $clog2(OUT_CH)  bias address
- b_data  input  DATA_WIDTH  signed bias
- out_data  output  DATA_WIDTH  signed result
- out_valid  output  1  one-cycle result strobe
- frame_done  output  1  pulses with the last result of a vector
- busy  output  1  high in MAC or EMIT

## Operation
- States:
  - LOAD: in_ready=1. Each cycle with in_valid=1 writes in_data to x[cnt_i] and increments cnt_i. Accepting element IN_CH-1 clears cnt_i and enters MAC.
  - MAC: one product per cycle, acc <= acc + x[cnt_i]*W[cnt_o][cnt_i]. The product is full precision (2*DATA_WIDTH) and sign-extended to ACC_WIDTH. The accumulator is cleared on entry to MAC for each output. After IN_CH products, go to EMIT.
  - EMIT: computes r = (acc + (bias[cnt_o] <<< FRAC_BITS) + 2^(FRAC_BITS-1)) >>> FRAC_BITS, an arithmetic shift with round-half-up.
    - Saturation: r saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and is registered onto out_data with out_valid=1.
    - If cnt_o = OUT_CH-1: assert frame_done, clear cnt_o, go to LOAD.
    - Otherwise: increment cnt_o and return to MAC.
- in_ready = 1 only in LOAD. in_valid outside LOAD is ignored and the data is dropped.
- Weight and bias writes take effect only while busy=0. Writes while busy=1 are dropped. w_we and b_we may be asserted in the same cycle.
- Weight, bias and x memories are not reset; their contents persist across rst.
- Reset: rst low at any time, including mid-MAC or mid-EMIT:
  - state forced to LOAD, cnt_i, cnt_o and acc forced to 0;
  - out_data, out_valid, frame_done and busy forced to 0, in_ready forced to 1;
  - any partial vector is discarded.

## Timing
- Reset values: out_data=0, out_valid=0, frame_done=0, busy=0, in_ready=1.
- Let T be the edge that accepts the last input element.
  - Edges T+1..T+IN_CH perform the MACs.
  - At edge T+IN_CH+1, out_data/out_valid for output 0 are registered.
  - Output k is registered at edge T+(k+1)*(IN_CH+1).
  - With defaults: outputs at T+17, T+34, T+51, T+68.
- out_valid and frame_done are single-cycle pulses. out_valid is never high on consecutive cycles when IN_CH ≥ 1.
- busy rises at T and falls at the edge that registers the last output. in_ready returns high in the same cycle, so the next vector may start immediately.
- in_valid may have gaps during LOAD; cnt_i advances only on accepted cycles.

## Structure
- Package se_pkg:
  - Q8.8 constants (DATA_WIDTH, FRAC_BITS);
  - state enum {LOAD, MAC, EMIT};
  - sat_round function (ACC_WIDTH to DATA_WIDTH, round-half-up plus saturate), shared with the later SE FC-expand stage.
- Sub-module se_mac_unit: a signed multiplier plus accumulator with clear and enable inputs, reused by the expand stage.
- Top level holds the FSM, counters, x register file, and the weight/bias memories.

## Test plan
Bench overrides IN_CH=4, OUT_CH=2.
- Sum test: weights row0 all 256 and row1 all -256, biases 0, inputs 256, 512, 768, 1024 -> out_data 2560 then -2560. frame_done is high with the second result; results arrive 5 and 10 cycles after the last input edge.
- Saturation: inputs all 32512, row0 weights 32512 -> 32767; row1 weights -32512 -> -32768.
- Bias and rounding:
  - inputs 1, 0, 0, 0, w[0][0]=128, bias0=0 -> 1 (128 rounds up);
  - bias1=256, row1 zeros -> 256.
- Handshake: in_valid held high with values 9..15 through MAC/EMIT -> in_ready=0 and no extra x writes. Gapped in_valid in LOAD still yields correct results.
- Write blocking: a w_we issued during MAC changes nothing -> the next frame uses the old weights.
- Reset mid-MAC: rst low for 2 cycles during output 0 -> all outputs 0, in_ready=1, no out_valid. A fresh vector then produces correct results using the retained weights.

Source files
------------

// File: rtl/se_pkg.sv
`default_nettype none
// ============================================================================
// Module : se_pkg
// Brief  : Shared definitions for the squeeze-excitation FC stages.
//          - Q8.8 fixed-point widths.
//          - FC sequencer state encoding.
//          - sat_round: round-half-up and saturate from accumulator to Q8.8.
// Rev    : 1.0  initial release
// ============================================================================
package se_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int ACC_WIDTH  = 40;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_e;

  // Limits and rounding constant are held one bit wider than the accumulator.
  // This keeps the rounding addition from overflowing at the extremes.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [ACC_WIDTH:0] ROUND_HALF =
    {{(ACC_WIDTH+1-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  // The input is an accumulator value at 2*FRAC_BITS fractional bits.
  // The result is rounded half-up to FRAC_BITS, then clamped to DATA_WIDTH.
  function automatic logic signed [DATA_WIDTH-1:0] sat_round(
    input logic signed [ACC_WIDTH-1:0] v
  );
    logic signed [ACC_WIDTH:0] t;
    t = {v[ACC_WIDTH-1], v};
    t = (t + ROUND_HALF) >>> FRAC_BITS;
    if (t > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (t < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return t[DATA_WIDTH-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/se_mac_unit.sv
`default_nettype none
// ============================================================================
// Module : se_mac_unit
// Brief  : Signed multiply-accumulate with synchronous clear and enable.
//          The product is full precision and sign-extended into the
//          accumulator. Clear takes priority over enable.
// Ports  : clk, rst (async active-low)
//          clr  - zero the accumulator on the next edge
//          en   - add a*b on the next edge
//          a, b - signed operands (A_WIDTH)
//          acc  - registered accumulator (ACC_W)
// Rev    : 1.0  initial release
// ============================================================================
module se_mac_unit
  import se_pkg::*;
#(
  parameter int A_WIDTH = DATA_WIDTH,
  parameter int ACC_W   = ACC_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [A_WIDTH-1:0] b,
  output logic signed [ACC_W-1:0]   acc
);

  logic signed [2*A_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]     acc_d;
  logic signed [ACC_W-1:0]     acc_q;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-2*A_WIDTH){prod[2*A_WIDTH-1]}}, prod};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule
`default_nettype wire

// File: rtl/se_fc_reduce.sv
`default_nettype none
// ============================================================================
// Module : se_fc_reduce
// Brief  : Serial fully-connected reduction stage of the SE layer.
//          The stage collects IN_CH Q8.8 inputs. It then runs OUT_CH dot
//          products, one MAC per cycle, against the weight memory. Each
//          result gets its bias, is rounded and saturated, and is emitted
//          as a one-cycle strobe.
// Ports  : clk, rst (async active-low)
//          in_data/in_valid/in_ready - input element stream (LOAD only)
//          w_we/w_addr/w_data        - weight write, addr = o*IN_CH+i
//          b_we/b_addr/b_data        - bias write
//          out_data/out_valid        - result stream, no backpressure
//          frame_done                - strobes with the last result
//          busy                      - high in MAC or EMIT; blocks writes
// Rev    : 1.0  initial release
// ============================================================================
module se_fc_reduce
  import se_pkg::*;
#(
  parameter int DATA_WIDTH = se_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = se_pkg::FRAC_BITS,
  parameter int IN_CH      = 16,
  parameter int OUT_CH     = 4,
  parameter int ACC_WIDTH  = se_pkg::ACC_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              w_we,
  input  logic [$clog2(IN_CH*OUT_CH)-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]             w_data,
  input  logic                              b_we,
  input  logic [$clog2(OUT_CH)-1:0]         b_addr,
  input  logic [DATA_WIDTH-1:0]             b_data,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic                              frame_done,
  output logic                              busy
);

  localparam int CI_W = (IN_CH  > 1) ? $clog2(IN_CH)  : 1;
  localparam int CO_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int W_AW = $clog2(IN_CH*OUT_CH);

  // Memories are deliberately left without reset so contents survive rst.
  logic signed [DATA_WIDTH-1:0] x_mem [IN_CH];
  logic signed [DATA_WIDTH-1:0] w_mem [IN_CH*OUT_CH];
  logic signed [DATA_WIDTH-1:0] b_mem [OUT_CH];

  state_e                  state_q, state_d;
  logic [CI_W-1:0]         cnt_i_q, cnt_i_d;
  logic [CO_W-1:0]         cnt_o_q, cnt_o_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    frame_done_q, frame_done_d;

  logic                    x_we;
  logic                    mac_clr;
  logic                    mac_en;
  logic [W_AW-1:0]         w_rd_idx;
  logic signed [ACC_WIDTH-1:0] mac_acc;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [ACC_WIDTH-1:0] round_in;

  assign in_ready = (state_q == LOAD);
  assign busy     = ~in_ready;

  assign w_rd_idx = W_AW'(int'(cnt_o_q) * IN_CH + int'(cnt_i_q));
  assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){b_mem[cnt_o_q][DATA_WIDTH-1]}}, b_mem[cnt_o_q]};
  // The bias is aligned to the product's 2*FRAC_BITS fraction before rounding.
  assign round_in = mac_acc + (bias_ext <<< FRAC_BITS);

  se_mac_unit #(
    .A_WIDTH (DATA_WIDTH),
    .ACC_W   (ACC_WIDTH)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (x_mem[cnt_i_q]),
    .b   (w_mem[w_rd_idx]),
    .acc (mac_acc)
  );

  always_comb begin
    state_d      = state_q;
    cnt_i_d      = cnt_i_q;
    cnt_o_d      = cnt_o_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    x_we         = 1'b0;
    mac_clr      = 1'b0;
    mac_en       = 1'b0;

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          x_we = 1'b1;
          if (cnt_i_q == CI_W'(IN_CH-1)) begin
            cnt_i_d = '0;
            mac_clr = 1'b1;     // accumulator starts clean for output 0
            state_d = MAC;
          end else begin
            cnt_i_d = cnt_i_q + 1'b1;
          end
        end
      end

      MAC: begin
        mac_en = 1'b1;
        if (cnt_i_q == CI_W'(IN_CH-1)) begin
          cnt_i_d = '0;
          state_d = EMIT;
        end else begin
          cnt_i_d = cnt_i_q + 1'b1;
        end
      end

      EMIT: begin
        out_data_d  = sat_round(round_in);
        out_valid_d = 1'b1;
        mac_clr     = 1'b1;     // ready for the next output's MAC run
        if (cnt_o_q == CO_W'(OUT_CH-1)) begin
          frame_done_d = 1'b1;
          cnt_o_d      = '0;
          state_d      = LOAD;
        end else begin
          cnt_o_d = cnt_o_q + 1'b1;
          state_d = MAC;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LOAD;
      cnt_i_q      <= '0;
      cnt_o_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_i_q      <= cnt_i_d;
      cnt_o_q      <= cnt_o_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (x_we)         x_mem[cnt_i_q] <= in_data;
    if (w_we && !busy) w_mem[w_addr] <= w_data;
    if (b_we && !busy) b_mem[b_addr] <= b_data;
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_se_fc_reduce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_se_fc_reduce
// Brief  : Scoreboard bench for se_fc_reduce with IN_CH=4, OUT_CH=2.
// Rev    : 1.0  initial release
// ============================================================================
module tb_se_fc_reduce;

  localparam int IN_CH  = 4;
  localparam int OUT_CH = 2;
  localparam int DW     = 16;
  localparam int LAT    = IN_CH + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 w_we;
  logic [2:0]           w_addr;
  logic signed [DW-1:0] w_data;
  logic                 b_we;
  logic [0:0]           b_addr;
  logic signed [DW-1:0] b_data;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 frame_done;
  logic                 busy;

  se_fc_reduce #(
    .DATA_WIDTH (16),
    .FRAC_BITS  (8),
    .IN_CH      (IN_CH),
    .OUT_CH     (OUT_CH),
    .ACC_WIDTH  (40)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [DW-1:0] d;
    logic                 fd;
    int                   c;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  int   consec_cnt = 0;
  int   stray_fd   = 0;
  logic prev_ov    = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int t_last   = 0;

  logic signed [DW-1:0] mw [IN_CH*OUT_CH];
  logic signed [DW-1:0] mb [OUT_CH];
  logic signed [DW-1:0] mx [IN_CH];

  // Output monitor: it only records. The comparisons are done by the test tasks.
  always @(negedge clk) begin
    rec_t r;
    if (out_valid === 1'b1) begin
      r.d = out_data; r.fd = frame_done; r.c = cyc;
      got_q.push_back(r);
      if (prev_ov) consec_cnt++;
    end
    if (frame_done === 1'b1 && out_valid !== 1'b1) stray_fd++;
    prev_ov = (out_valid === 1'b1);
  end

  function automatic logic signed [DW-1:0] model_out(input int o);
    longint acc = 0;
    for (int i = 0; i < IN_CH; i++) acc += longint'(mx[i]) * longint'(mw[o*IN_CH+i]);
    acc = acc + longint'(mb[o]) * 256 + 128;
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return DW'(acc);
  endfunction

  task automatic write_w(input int a, input logic signed [DW-1:0] d);
    @(negedge clk); w_we = 1'b1; w_addr = 3'(a); w_data = d;
    @(posedge clk); #1; w_we = 1'b0;
    mw[a] = d;
  endtask

  task automatic write_b(input int a, input logic signed [DW-1:0] d);
    @(negedge clk); b_we = 1'b1; b_addr = 1'(a); b_data = d;
    @(posedge clk); #1; b_we = 1'b0;
    mb[a] = d;
  endtask

  task automatic send_vec(input logic signed [DW-1:0] v0, v1, v2, v3, input int gap);
    logic signed [DW-1:0] v [IN_CH];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int i = 0; i < IN_CH; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); in_valid = 1'b0;
      end
      @(negedge clk); in_valid = 1'b1; in_data = v[i];
      mx[i] = v[i];
    end
    @(posedge clk); #1; t_last = cyc;
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic push_exp(input int k, input logic signed [DW-1:0] d);
    rec_t r;
    r.d = d; r.fd = (k == OUT_CH-1); r.c = t_last + (k+1)*LAT;
    exp_q.push_back(r);
  endtask

  task automatic push_model();
    for (int o = 0; o < OUT_CH; o++) push_exp(o, model_out(o));
  endtask

  task automatic wait_got(input int n);
    for (int k = 0; k < 400 && got_q.size() < n; k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; w_we = 1'b0; w_addr = '0;
    w_data = '0; b_we = 1'b0; b_addr = '0; b_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (out_data !== 16'sd0) $display("FAIL reset_out_data got %0d want 0", out_data); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_sum();
    rec_t g, e;
    for (int i = 0; i < IN_CH; i++) begin
      write_w(i, 16'sd256);
      write_w(IN_CH+i, -16'sd256);
    end
    write_b(0, 16'sd0); write_b(1, 16'sd0);
    send_vec(16'sd256, 16'sd512, 16'sd768, 16'sd1024, 0);
    push_exp(0, 16'sd2560); push_exp(1, -16'sd2560);
    wait_got(2);
    n_checks++; if (got_q.size() != 2) $display("FAIL sum_count got %0d want 2", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g.d !== e.d) $display("FAIL sum_data got %0d want %0d", g.d, e.d); else n_pass++;
      n_checks++; if (g.fd !== e.fd) $display("FAIL sum_frame_done got %b want %b", g.fd, e.fd); else n_pass++;
      n_checks++; if (g.c - t_last !== e.c - t_last) $display("FAIL sum_latency got %0d want %0d", g.c - t_last, e.c - t_last); else n_pass++;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL sum_busy_after got %b want 0", busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL sum_in_ready_after got %b want 1", in_ready); else n_pass++;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    rec_t g, e;
    for (int i = 0; i < IN_CH; i++) begin
      write_w(i, 16'sd32512);
      write_w(IN_CH+i, -16'sd32512);
    end
    send_vec(16'sd32512, 16'sd32512, 16'sd32512, 16'sd32512, 0);
    push_exp(0, 16'sd32767); push_exp(1, -16'sd32768);
    wait_got(2);
    n_checks++; if (got_q.size() != 2) $display("FAIL sat_count got %0d want 2", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g.d !== e.d) $display("FAIL sat_data got %0d want %0d", g.d, e.d); else n_pass++;
      n_checks++; if (g.c !== e.c) $display("FAIL sat_timing got %0d want %0d", g.c, e.c); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_bias_round();
    rec_t g, e;
    write_w(0, 16'sd128);
    for (int i = 1; i < IN_CH*OUT_CH; i++) write_w(i, 16'sd0);
    write_b(0, 16'sd0); write_b(1, 16'sd256);
    send_vec(16'sd1, 16'sd0, 16'sd0, 16'sd0, 0);
    push_exp(0, 16'sd1); push_exp(1, 16'sd256);
    wait_got(2);
    n_checks++; if (got_q.size() != 2) $display("FAIL bias_count got %0d want 2", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g.d !== e.d) $display("FAIL bias_round_data got %0d want %0d", g.d, e.d); else n_pass++;
      n_checks++; if (g.fd !== e.fd) $display("FAIL bias_frame_done got %b want %b", g.fd, e.fd); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_handshake();
    rec_t g, e;
    int   r;
    for (int a = 0; a < IN_CH*OUT_CH; a++) begin
      r = int'($urandom_range(0, 1023)) - 512;
      write_w(a, DW'(r));
    end
    write_b(0, 16'sd300); write_b(1, -16'sd700);
    send_vec(16'sd1000, -16'sd2000, 16'sd3000, 16'sd77, 0);
    push_model();
    // Hold in_valid high with junk while the stage is busy.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      in_valid = 1'b1; in_data = DW'(9 + k % 7);
      n_checks++; if (in_ready !== 1'b0) $display("FAIL hs_in_ready_busy got %b want 0", in_ready); else n_pass++;
    end
    in_valid = 1'b0;
    // Gapped input vector.
    send_vec(-16'sd512, 16'sd4096, 16'sd5, -16'sd9000, 2);
    push_model();
    wait_got(4);
    n_checks++; if (got_q.size() != 4) $display("FAIL hs_count got %0d want 4", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g.d !== e.d) $display("FAIL hs_data got %0d want %0d", g.d, e.d); else n_pass++;
      n_checks++; if (g.fd !== e.fd) $display("FAIL hs_frame_done got %b want %b", g.fd, e.fd); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_write_block();
    rec_t g, e;
    for (int i = 0; i < IN_CH; i++) begin
      write_w(i, 16'sd256);
      write_w(IN_CH+i, 16'sd512);
    end
    write_b(0, 16'sd0); write_b(1, 16'sd0);
    send_vec(16'sd256, 16'sd256, 16'sd256, 16'sd256, 0);
    push_exp(0, 16'sd1024); push_exp(1, 16'sd2048);
    // Writes issued mid-MAC must be dropped.
    @(negedge clk);
    w_we = 1'b1; w_addr = 3'd0; w_data = 16'sd32767;
    b_we = 1'b1; b_addr = 1'd0; b_data = 16'sd1000;
    @(negedge clk);
    w_we = 1'b0; b_we = 1'b0;
    wait_got(2);
    send_vec(16'sd512, 16'sd0, 16'sd0, 16'sd0, 0);
    push_exp(0, 16'sd512); push_exp(1, 16'sd1024);
    wait_got(4);
    n_checks++; if (got_q.size() != 4) $display("FAIL wblk_count got %0d want 4", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g.d !== e.d) $display("FAIL wblk_data got %0d want %0d", g.d, e.d); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_mac();
    rec_t g, e;
    send_vec(16'sd100, 16'sd200, 16'sd300, 16'sd400, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (out_data !== 16'sd0) $display("FAIL rmid_out_data got %0d want 0", out_data); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL rmid_frame_done got %b want 0", frame_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready got %b want 1", in_ready); else n_pass++;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++; if (got_q.size() != 0) $display("FAIL rmid_no_output got %0d want 0", got_q.size()); else n_pass++;
    got_q.delete();
    send_vec(-16'sd300, 16'sd50, 16'sd1234, -16'sd8, 0);
    push_model();
    wait_got(2);
    n_checks++; if (got_q.size() != 2) $display("FAIL rmid_fresh_count got %0d want 2", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g.d !== e.d) $display("FAIL rmid_fresh_data got %0d want %0d", g.d, e.d); else n_pass++;
      n_checks++; if (g.c !== e.c) $display("FAIL rmid_fresh_timing got %0d want %0d", g.c, e.c); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    rec_t g, e;
    send_vec(16'sd11, 16'sd22, 16'sd33, 16'sd44, 0);
    push_model();
    for (int k = 0; k < 100 && busy === 1'b1; k++) @(negedge clk);
    send_vec(-16'sd700, 16'sd800, -16'sd900, 16'sd1000, 0);
    push_model();
    wait_got(4);
    n_checks++; if (got_q.size() != 4) $display("FAIL b2b_count got %0d want 4", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g.d !== e.d) $display("FAIL b2b_data got %0d want %0d", g.d, e.d); else n_pass++;
      n_checks++; if (g.fd !== e.fd) $display("FAIL b2b_frame_done got %b want %b", g.fd, e.fd); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
    n_checks++; if (consec_cnt != 0) $display("FAIL out_valid_consecutive got %0d want 0", consec_cnt); else n_pass++;
    n_checks++; if (stray_fd != 0) $display("FAIL frame_done_without_valid got %0d want 0", stray_fd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sum();
    test_saturation();
    test_bias_round();
    test_handshake();
    test_write_block();
    test_reset_mid_mac();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
